// File: rtl/arbiter_types.sv
// Shared types and default widths for the icache/dcache memory arbiter.
package arbiter_types;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int LINE_WIDTH_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin pick: a lone requester wins, a collision goes to
// whoever was not granted last.
import arbiter_types::*;

module arb_rr_select (
  input  logic req_i,
  input  logic req_d,
  input  req_e last,
  output req_e grant
);

  // Combinational winner selection; defaults to icache when nobody asks.
  always_comb begin
    grant = REQ_I;
    if (req_i && req_d) begin
      grant = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache reads and dcache reads/writebacks onto one physical
// memory port. One transaction in flight; pmem side driven from registers.
import arbiter_types::*;

module cache_arbiter #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  state_e                state_q, state_d;
  req_e                  last_q, last_d;   // also identifies the current owner
  req_e                  gnt;
  logic                  load, capture;
  logic                  op_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic                  busy;

  arb_rr_select u_rr (
    .req_i (i_read),
    .req_d (d_read | d_write),
    .last  (last_q),
    .grant (gnt)
  );

  // Next-state: grant from IDLE, wait for memory in BUSY, one RESP cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_read || d_read || d_write) begin
          load    = 1'b1;
          last_d  = gnt;
          state_d = (gnt == REQ_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and last-grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Request latch at grant and read-line capture on memory response.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (load) begin
        // A simultaneous dcache read+write is treated as the writeback.
        op_wr_q <= (gnt == REQ_D) && d_write;
        addr_q  <= (gnt == REQ_D) ? d_address : i_address;
        wdata_q <= (gnt == REQ_D) ? d_wdata : '0;
      end
      if (capture && !op_wr_q) begin
        if (state_q == BUSY_I) i_rdata_q <= pmem_rdata;
        else                   d_rdata_q <= pmem_rdata;
      end
    end
  end

  // Outputs are pure decodes of registered state.
  assign busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign pmem_read    = busy && !op_wr_q;
  assign pmem_write   = busy &&  op_wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state_q == RESP) && (last_q == REQ_I);
  assign d_resp       = (state_q == RESP) && (last_q == REQ_D);
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: hand sequences plus a cycle table.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] LINE_I  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LW-1:0] LINE_D  = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [LW-1:0] LINE_I2 = 128'hFFFF_0000_AAAA_5555_1234_5678_9ABC_DEF0;
  localparam logic [LW-1:0] PAT_A5  = {16{8'hA5}};

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // in = {i_read, d_read, d_write, pmem_resp}; ex = {pmem_read, pmem_write, i_resp, d_resp}
  typedef struct packed {
    logic [3:0] in;
    logic [3:0] ex;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = 8'b1000_0000;  // lone icache request in IDLE
    vecs[1]  = 8'b1000_1000;  // BUSY_I
    vecs[2]  = 8'b0000_1000;  // icache drops request, access continues
    vecs[3]  = 8'b0001_1000;  // third busy cycle, memory answers
    vecs[4]  = 8'b0000_0010;  // RESP: i_resp pulse
    vecs[5]  = 8'b0000_0000;
    vecs[6]  = 8'b1100_0000;  // collision, last=I -> dcache read
    vecs[7]  = 8'b1001_1000;  // BUSY_D, latency 1
    vecs[8]  = 8'b1000_0001;  // RESP: d_resp, icache still pending
    vecs[9]  = 8'b1000_0000;  // IDLE: icache granted now
    vecs[10] = 8'b0001_1000;
    vecs[11] = 8'b1110_0010;  // RESP must not sample the collision
    vecs[12] = 8'b1110_0000;  // IDLE: last=I -> dcache, read+write -> write
    vecs[13] = 8'b1111_0100;
    vecs[14] = 8'b1100_0001;  // RESP: d_resp
    vecs[15] = 8'b1100_0000;  // IDLE: last=D -> icache
    vecs[16] = 8'b0001_1000;
    vecs[17] = 8'b0001_0010;  // pmem_resp in RESP ignored
    vecs[18] = 8'b0001_0000;  // spurious pmem_resp in IDLE ignored
    vecs[19] = 8'b0000_0000;

    // Reset state
    rst = 1'b1;
    clr_inputs();
    tick(); tick(); smp();
    chk("rst pmem_read", LW'(pmem_read), 0);
    chk("rst pmem_write", LW'(pmem_write), 0);
    chk("rst i_resp", LW'(i_resp), 0);
    chk("rst d_resp", LW'(d_resp), 0);
    chk("rst pmem_address", LW'(pmem_address), 0);
    chk("rst pmem_wdata", pmem_wdata, 0);
    chk("rst i_rdata", i_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    tick();
    rst = 1'b0;

    // icache read, memory latency 3
    tick(); i_read = 1; i_address = 16'h0040; pmem_rdata = LINE_I;
    smp(); chk("ird idle pmem_read", LW'(pmem_read), 0);
    tick(); i_read = 0; i_address = '0;
    smp(); chk("ird busy1 pmem_read", LW'(pmem_read), 1);
    chk("ird pmem_address", LW'(pmem_address), 16'h0040);
    tick();
    smp(); chk("ird busy2 pmem_read", LW'(pmem_read), 1);
    tick(); pmem_resp = 1;
    smp(); chk("ird busy3 pmem_read", LW'(pmem_read), 1);
    tick(); pmem_resp = 0; pmem_rdata = '0;
    smp(); chk("ird resp pmem_read", LW'(pmem_read), 0);
    chk("ird i_resp", LW'(i_resp), 1);
    chk("ird i_rdata", i_rdata, LINE_I);
    chk("ird d_resp", LW'(d_resp), 0);
    tick();
    smp(); chk("ird i_resp one pulse", LW'(i_resp), 0);
    chk("ird i_rdata hold", i_rdata, LINE_I);

    // dcache writeback
    tick(); d_write = 1; d_address = 16'h1230; d_wdata = PAT_A5;
    smp(); chk("dwr idle pmem_write", LW'(pmem_write), 0);
    tick(); d_write = 0; d_address = '0; d_wdata = '0;
    smp(); chk("dwr pmem_write", LW'(pmem_write), 1);
    chk("dwr pmem_read", LW'(pmem_read), 0);
    chk("dwr pmem_address", LW'(pmem_address), 16'h1230);
    chk("dwr pmem_wdata", pmem_wdata, PAT_A5);
    tick(); pmem_resp = 1; pmem_rdata = LINE_D;
    smp(); chk("dwr pmem_write held", LW'(pmem_write), 1);
    tick(); pmem_resp = 0;
    smp(); chk("dwr d_resp", LW'(d_resp), 1);
    chk("dwr pmem_write off", LW'(pmem_write), 0);
    chk("dwr i_resp", LW'(i_resp), 0);
    chk("dwr d_rdata untouched", d_rdata, 0);
    chk("dwr i_rdata hold", i_rdata, LINE_I);
    tick();
    smp(); chk("dwr d_resp one pulse", LW'(d_resp), 0);

    // Cycle table
    i_address = 16'h0100; d_address = 16'h0200; pmem_rdata = LINE_I2;
    for (int k = 0; k < 20; k++) begin
      tick();
      {i_read, d_read, d_write, pmem_resp} = vecs[k].in;
      smp();
      chk($sformatf("vec%0d pmem_read", k),  LW'(pmem_read),  LW'(vecs[k].ex[3]));
      chk($sformatf("vec%0d pmem_write", k), LW'(pmem_write), LW'(vecs[k].ex[2]));
      chk($sformatf("vec%0d i_resp", k),     LW'(i_resp),     LW'(vecs[k].ex[1]));
      chk($sformatf("vec%0d d_resp", k),     LW'(d_resp),     LW'(vecs[k].ex[0]));
    end

    // Collision right after reset: dcache first, then icache
    do_reset();
    i_read = 1; d_read = 1; i_address = 16'h0011; d_address = 16'h0022;
    tick();
    smp(); chk("rr first addr", LW'(pmem_address), 16'h0022);
    chk("rr first pmem_read", LW'(pmem_read), 1);
    tick(); pmem_resp = 1; pmem_rdata = LINE_D;
    tick(); pmem_resp = 0;
    smp(); chk("rr first d_resp", LW'(d_resp), 1);
    chk("rr first i_resp", LW'(i_resp), 0);
    chk("rr first d_rdata", d_rdata, LINE_D);
    tick(); d_read = 0;
    smp(); chk("rr gap pmem_read", LW'(pmem_read), 0);
    tick();
    smp(); chk("rr second addr", LW'(pmem_address), 16'h0011);
    chk("rr second pmem_read", LW'(pmem_read), 1);
    tick(); pmem_resp = 1; pmem_rdata = LINE_I2; i_read = 0;
    tick(); pmem_resp = 0;
    smp(); chk("rr second i_resp", LW'(i_resp), 1);
    chk("rr second i_rdata", i_rdata, LINE_I2);
    chk("rr second d_rdata hold", d_rdata, LINE_D);

    // Reset during BUSY_D
    tick();
    do_reset();
    d_read = 1; d_address = 16'h2000;
    tick(); d_read = 0;
    smp(); chk("rstmid busy pmem_read", LW'(pmem_read), 1);
    tick(); rst = 1;
    tick(); rst = 0; pmem_resp = 1; pmem_rdata = LINE_I;
    smp(); chk("rstmid pmem_read dropped", LW'(pmem_read), 0);
    chk("rstmid d_resp", LW'(d_resp), 0);
    tick(); pmem_resp = 0;
    smp(); chk("rstmid late d_resp", LW'(d_resp), 0);
    chk("rstmid late i_resp", LW'(i_resp), 0);
    chk("rstmid d_rdata", d_rdata, 0);
    chk("rstmid late pmem_read", LW'(pmem_read), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, physical address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, cache line width in bits.
REQ-003 SHALL have ports `clk  in  1  clock`, all state on rising edge; `rst  in  1  reset`, synchronous, active-high.
REQ-004 SHALL have ports `i_read  in  1  icache line read request`; `i_address  in  ADDR_WIDTH  icache line address`.
REQ-005 SHALL have ports `i_rdata  out  LINE_WIDTH  icache read line`; `i_resp  out  1  icache done pulse`.
REQ-006 SHALL have ports `d_read  in  1  dcache read request`; `d_write  in  1  dcache writeback request`.
REQ-007 SHALL have ports `d_address  in  ADDR_WIDTH  dcache address`; `d_wdata  in  LINE_WIDTH  dcache writeback line`.
REQ-008 SHALL have ports `d_rdata  out  LINE_WIDTH  dcache read line`; `d_resp  out  1  dcache done pulse`.
REQ-009 SHALL have ports `pmem_read  out  1`; `pmem_write  out  1`; `pmem_address  out  ADDR_WIDTH`; `pmem_wdata  out  LINE_WIDTH`.
REQ-010 SHALL have ports `pmem_rdata  in  LINE_WIDTH`; `pmem_resp  in  1`.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-012 IDLE with exactly one requester pending SHALL grant that requester at the next edge, entering BUSY_I or BUSY_D.
REQ-013 IDLE with both pending SHALL grant the requester not granted last (round-robin); after reset, last-grant SHALL be icache, so dcache wins first.
REQ-014 At grant, address, op and wdata SHALL be latched into registers; pmem_* outputs SHALL be driven only from these registers.
REQ-015 pmem_read/pmem_write SHALL assert from the first BUSY cycle and stay high until the cycle pmem_resp is sampled high; latency from request to pmem strobe is exactly 1 cycle.
REQ-016 If d_read and d_write are both high at grant, the op SHALL be write; pmem_read and pmem_write SHALL never be high together.
REQ-017 On pmem_resp in BUSY, pmem_rdata SHALL be captured (reads only) and the FSM SHALL enter RESP.
REQ-018 In RESP, the granted requester's resp SHALL be high for exactly one cycle, with its rdata holding the captured line; the FSM SHALL then return to IDLE.
REQ-019 i_rdata/d_rdata SHALL hold their last captured value until the next capture for that port.
REQ-020 The non-granted requester SHALL see resp low throughout; its request SHALL stay pending, not dropped.
REQ-021 pmem_resp in IDLE or RESP SHALL be ignored.
REQ-022 A requester deasserting mid-transaction SHALL NOT abort it; the pmem access completes and resp still pulses.
REQ-023 Request inputs SHALL NOT be sampled in RESP; a new grant occurs no earlier than the IDLE cycle after RESP.
REQ-024 Back-to-back throughput SHALL be pmem latency + 2 cycles per transaction.

Reset
REQ-025 On rst, FSM SHALL go to IDLE and last-grant to icache; pmem_read, pmem_write, i_resp and d_resp SHALL be 0.
REQ-026 On rst, pmem_address, pmem_wdata, i_rdata and d_rdata SHALL be 0.
REQ-027 Reset mid-transaction SHALL drop strobes the next cycle with no resp issued; a later pmem_resp SHALL be ignored.

Structure
REQ-028 Package arbiter_types SHALL hold the state enum, the requester enum (REQ_I, REQ_D) and default width constants.
REQ-029 Round-robin selection SHALL live in sub-module arb_rr_select (inputs: two requests and last grant; output: grant).

Verification
REQ-030 Directed scenario: i_read, i_address=0x0040 alone, memory latency 3 -> pmem_read high 3 cycles, pmem_address=0x0040; i_resp one pulse with i_rdata=line; d_resp stays 0.
REQ-031 Directed scenario: d_write, d_address=0x1230, d_wdata=0xA5 pattern -> pmem_write with identical address and data; pmem_read stays 0; d_resp one pulse.
REQ-032 Directed scenario: i_read and d_read together at reset-fresh start -> D served first, then I; alternation continues on repeated collisions.
REQ-033 Directed scenario: rst asserted during BUSY_D -> strobes 0 next cycle; no d_resp; subsequent pmem_resp ignored.
REQ-034 Directed scenario: d_read and d_write together -> write issued; spurious pmem_resp in IDLE -> no resp and no state change.
